// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package: shared types for HWPE streaming blocks.
// Holds the TCDM reader control/flag bundles and its FSM encoding.
package hwpe_stream_package;

    // Widest transfer length any reader instance can be configured for.
    localparam int unsigned READER_CNT_MAX_W = 32;

    typedef enum logic {
        READER_IDLE    = 1'b0,
        READER_WORKING = 1'b1
    } reader_state_e;

    typedef struct packed {
        logic                        req_start;
        logic [31:0]                 base_addr;
        logic [READER_CNT_MAX_W-1:0] trans_size;
        logic [31:0]                 stride;
    } ctrl_reader_t;

    typedef struct packed {
        logic ready_start;
        logic done;
        logic in_progress;
    } flags_reader_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready data stream bundle.
// A word moves on every cycle where valid and ready are both high.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (
        output valid, data, strb,
        input  ready
    );

    modport sink (
        input  valid, data, strb,
        output ready
    );

endinterface

// File: rtl/hwpe_stream_intf_tcdm.sv
// hwpe_stream_intf_tcdm: 32-bit TCDM port bundle.
// wen=1 marks a read; r_valid returns data in request order.
interface hwpe_stream_intf_tcdm;

    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/hwpe_stream_fifo.sv
// hwpe_stream_fifo: registered circular buffer, power-of-two depth.
// A pushed word becomes visible at the head on the following cycle.
module hwpe_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        push_valid_i,
    input  logic [DATA_WIDTH-1:0]       push_data_i,
    input  logic                        pop_ready_i,
    output logic                        pop_valid_o,
    output logic [DATA_WIDTH-1:0]       pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q;
    logic [AW-1:0]         rd_q;
    logic [AW:0]           cnt_q;
    logic                  push;
    logic                  pop;

    assign push = push_valid_i && (cnt_q != FULL) && !clear_i;
    assign pop  = pop_ready_i && (cnt_q != '0) && !clear_i;

    assign pop_valid_o = (cnt_q != '0);
    assign pop_data_o  = mem_q[rd_q];
    assign count_o     = cnt_q;

    // Storage array: only written slots are ever read, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // Pointers and fill level; clear empties the buffer in one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// hwpe_stream_tcdm_reader: strided TCDM read engine feeding a stream.
// Requests are credit-limited so the response FIFO can never overflow.
module hwpe_stream_tcdm_reader
    import hwpe_stream_package::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   test_mode_i,
    input  logic                   clear_i,
    hwpe_stream_intf_tcdm.master   tcdm,
    hwpe_stream_intf_stream.source stream,
    input  ctrl_reader_t           ctrl_i,
    output flags_reader_t          flags_o
);

    localparam int unsigned OW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OW:0] DEPTH = (OW+1)'(FIFO_DEPTH);

    reader_state_e        state_q;
    logic [CNT_WIDTH-1:0] issued_q;
    logic [CNT_WIDTH-1:0] size_q;
    logic [31:0]          addr_q;
    logic [31:0]          stride_q;
    logic [OW-1:0]        outst_q;
    logic [OW-1:0]        outst_d;
    logic [OW-1:0]        fifo_cnt;
    logic [31:0]          fifo_data;
    logic                 fifo_valid;
    logic                 working;
    logic                 credit;
    logic                 req;
    logic                 fire;
    logic                 finish;
    logic                 idle_ok;
    logic                 push;
    logic                 unused_bits;

    assign working = (state_q == READER_WORKING);
    assign credit  = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < DEPTH;
    assign req     = working && (issued_q < size_q) && credit;
    assign fire    = req && tcdm.gnt;
    assign finish  = working && (issued_q == size_q) && (outst_q == '0);
    // Reads still in flight after a clear must drain before a new job.
    assign idle_ok = !working && (outst_q == '0);
    // Only the live job may fill the buffer; stale replies are dropped.
    assign push    = tcdm.r_valid && working && !clear_i;

    assign unused_bits = ^{test_mode_i, ctrl_i.trans_size};

    hwpe_stream_fifo #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) i_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .push_valid_i (push),
        .push_data_i  (tcdm.r_data),
        .pop_ready_i  (stream.ready),
        .pop_valid_o  (fifo_valid),
        .pop_data_o   (fifo_data),
        .count_o      (fifo_cnt)
    );

    // Next outstanding count: grant adds one, response retires one.
    always_comb begin
        outst_d = outst_q;
        unique case ({fire, tcdm.r_valid && (outst_q != '0)})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: ;
        endcase
    end

    // Outstanding register deliberately ignores clear so late replies are counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    // Job FSM: latch the job, then step address and count on each grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= READER_IDLE;
            issued_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            stride_q <= '0;
        end else if (clear_i) begin
            state_q  <= READER_IDLE;
            issued_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            unique case (state_q)
                READER_IDLE: begin
                    if (ctrl_i.req_start && idle_ok) begin
                        state_q  <= READER_WORKING;
                        issued_q <= '0;
                        size_q   <= ctrl_i.trans_size[CNT_WIDTH-1:0];
                        addr_q   <= ctrl_i.base_addr;
                        stride_q <= ctrl_i.stride;
                    end
                end
                READER_WORKING: begin
                    if (fire) begin
                        issued_q <= issued_q + 1'b1;
                        addr_q   <= addr_q + stride_q;
                    end
                    if (finish) begin
                        state_q <= READER_IDLE;
                    end
                end
                default: state_q <= READER_IDLE;
            endcase
        end
    end

    assign tcdm.req  = req;
    assign tcdm.add  = addr_q;
    assign tcdm.wen  = 1'b1;
    assign tcdm.be   = 4'hF;
    assign tcdm.data = '0;

    assign stream.valid = fifo_valid;
    assign stream.data  = fifo_data;
    assign stream.strb  = 4'hF;

    assign flags_o.ready_start = idle_ok;
    assign flags_o.done        = finish;
    assign flags_o.in_progress = working || fifo_valid;

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Bench for hwpe_stream_tcdm_reader: random grant/ready/latency
// against a queue-based model of the expected address/data sequence.
module tb_hwpe_stream_tcdm_reader;
    import hwpe_stream_package::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_mode = 1'b0;
    logic          clear = 1'b0;
    ctrl_reader_t  ctrl;
    flags_reader_t flags;

    hwpe_stream_intf_tcdm tcdm_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) stream_if ();

    always #5 clk = ~clk;

    hwpe_stream_tcdm_reader #(
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_mode_i (test_mode),
        .clear_i     (clear),
        .tcdm        (tcdm_if),
        .stream      (stream_if),
        .ctrl_i      (ctrl),
        .flags_o     (flags)
    );

    int n_run = 0;
    int n_fail = 0;
    logic [31:0] salt;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int done_cnt, done_cyc, first_gnt, first_valid, max_outst;
    int unstable, bad_ctl, stall_grants, req_seen, timeout, bad_prog;

    // Memory contents seen by the reader: a scramble of the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt ^ 32'h5A5A_C3C3;
    endfunction

    // Reference: word i of a job is read from base + i*stride (mod 2^32).
    function automatic void build_model(input logic [31:0] base,
                                        input logic [31:0] stride,
                                        input int size);
        logic [31:0] a;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < size; i++) begin
            a = base + stride * 32'(i);
            exp_addr.push_back(a);
            exp_data.push_back(word_of(a));
        end
    endfunction

    task automatic start(input logic [31:0] base, input logic [31:0] stride,
                         input int size);
        ctrl.req_start  = 1'b1;
        ctrl.base_addr  = base;
        ctrl.stride     = stride;
        ctrl.trans_size = 32'(size);
        @(negedge clk);
        ctrl.req_start = 1'b0;
    endtask

    // Cycle engine: plays TCDM memory and stream sink, records observations.
    task automatic run(input int gnt_pct, input int rdy_pct, input int stall,
                       input int max_lat, input int inj, input int budget);
        logic [31:0] rq_addr[$];
        int rq_due[$];
        int outst;
        int tail;
        bit prev_wait;
        logic [31:0] prev_add;
        bit g;
        bit r;
        outst = 0; tail = -1; prev_wait = 0; prev_add = '0;
        got_addr.delete(); got_data.delete();
        done_cnt = 0; done_cyc = -1; first_gnt = -1; first_valid = -1;
        max_outst = 0; unstable = 0; bad_ctl = 0; stall_grants = 0;
        req_seen = 0; timeout = 0; bad_prog = 0;
        for (int cyc = 0; tail != 0; cyc++) begin
            if (cyc >= budget) begin
                timeout = 1;
                break;
            end
            ctrl.req_start = (cyc == inj);
            if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
                tcdm_if.r_valid = 1'b1;
                tcdm_if.r_data  = word_of(rq_addr.pop_front());
                void'(rq_due.pop_front());
                outst--;
            end else begin
                tcdm_if.r_valid = 1'b0;
                tcdm_if.r_data  = $urandom;
            end
            if (tcdm_if.req) begin
                req_seen++;
                if (tcdm_if.wen !== 1'b1 || tcdm_if.be !== 4'hF) bad_ctl++;
                if (prev_wait && tcdm_if.add !== prev_add) unstable++;
            end else if (prev_wait) begin
                unstable++;
            end
            g = (int'($urandom_range(99)) < gnt_pct);
            tcdm_if.gnt = g;
            if (tcdm_if.req && g) begin
                got_addr.push_back(tcdm_if.add);
                rq_addr.push_back(tcdm_if.add);
                rq_due.push_back(cyc + 1 + int'($urandom_range(max_lat)));
                if (first_gnt < 0) first_gnt = cyc;
                if (cyc < stall) stall_grants++;
                outst++;
            end
            if (outst > max_outst) max_outst = outst;
            prev_wait = tcdm_if.req && !g;
            prev_add  = tcdm_if.add;
            r = (cyc >= stall) && (int'($urandom_range(99)) < rdy_pct);
            stream_if.ready = r;
            if (stream_if.valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stream_if.strb !== 4'hF) bad_ctl++;
                if (!flags.in_progress) bad_prog++;
                if (r) got_data.push_back(stream_if.data);
            end
            if (flags.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (tail > 0) tail--;
            else if (tail < 0 && done_cnt > 0 && !stream_if.valid) tail = 4;
            @(negedge clk);
        end
        tcdm_if.gnt = 1'b0;
        tcdm_if.r_valid = 1'b0;
        stream_if.ready = 1'b0;
        ctrl.req_start = 1'b0;
    endtask

    task automatic test_reset();
        ctrl = '0;
        tcdm_if.gnt = 1'b0;
        tcdm_if.r_valid = 1'b0;
        tcdm_if.r_data = '0;
        stream_if.ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({tcdm_if.req, stream_if.valid, flags.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: req/valid/done=%b want 000",
                     {tcdm_if.req, stream_if.valid, flags.done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if ({tcdm_if.req, stream_if.valid, flags.done, flags.ready_start,
             flags.in_progress} !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_state: req/valid/done/rs/prog=%b want 00010",
                     {tcdm_if.req, stream_if.valid, flags.done,
                      flags.ready_start, flags.in_progress});
        end
    endtask

    task automatic test_basic();
        salt = 32'h1111_0000;
        build_model(32'h1000, 32'd4, 8);
        start(32'h1000, 32'd4, 8);
        run(100, 100, 0, 0, -1, 200);
        n_run++;
        if (got_addr.size() != 8 || got_data.size() != 8 || timeout != 0) begin
            n_fail++;
            $display("FAIL basic_count: addr=%0d data=%0d to=%0d want 8 8 0",
                     got_addr.size(), got_data.size(), timeout);
        end else begin
            foreach (exp_addr[i]) begin
                n_run++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL basic_word[%0d]: add=%h data=%h want %h %h", i,
                             got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        n_run++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d want 1", done_cnt);
        end
        n_run++;
        if (first_valid - first_gnt != 2) begin
            n_fail++;
            $display("FAIL basic_latency: gnt->valid=%0d want 2",
                     first_valid - first_gnt);
        end
        n_run++;
        if (bad_ctl != 0 || bad_prog != 0) begin
            n_fail++;
            $display("FAIL basic_ctl: bad wen/be/strb=%0d bad prog=%0d want 0 0",
                     bad_ctl, bad_prog);
        end
    endtask

    task automatic test_random_gnt();
        logic [31:0] base;
        logic [31:0] stride;
        for (int it = 0; it < 4; it++) begin
            salt = $urandom;
            base = $urandom;
            stride = 32'($urandom_range(64, 1)) << 2;
            build_model(base, stride, 6);
            start(base, stride, 6);
            run(50, 70, 0, 2, -1, 400);
            n_run++;
            if (got_addr.size() != 6 || got_data.size() != 6 || timeout != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_count: addr=%0d data=%0d to=%0d want 6 6 0",
                         it, got_addr.size(), got_data.size(), timeout);
            end else begin
                foreach (exp_addr[i]) begin
                    n_run++;
                    if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_word[%0d]: add=%h data=%h want %h %h",
                                 it, i, got_addr[i], got_data[i],
                                 exp_addr[i], exp_data[i]);
                    end
                end
            end
            n_run++;
            if (max_outst > 4 || unstable != 0 || done_cnt != 1 || bad_prog != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_rules: outst=%0d unstable=%0d done=%0d prog=%0d want <=4 0 1 0",
                         it, max_outst, unstable, done_cnt, bad_prog);
            end
        end
    endtask

    task automatic test_backpressure();
        salt = 32'h2222_0000;
        build_model(32'h0000_8000, 32'd4, 10);
        start(32'h0000_8000, 32'd4, 10);
        run(100, 100, 20, 0, -1, 300);
        n_run++;
        if (stall_grants != 4) begin
            n_fail++;
            $display("FAIL bp_stall_grants: got %0d want 4", stall_grants);
        end
        n_run++;
        if (got_data.size() != 10 || timeout != 0) begin
            n_fail++;
            $display("FAIL bp_count: data=%0d to=%0d want 10 0",
                     got_data.size(), timeout);
        end else begin
            foreach (exp_data[i]) begin
                n_run++;
                if (got_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL bp_word[%0d]: got %h want %h", i,
                             got_data[i], exp_data[i]);
                end
            end
        end
        n_run++;
        if (done_cnt != 1 || bad_prog != 0) begin
            n_fail++;
            $display("FAIL bp_done: done=%0d prog=%0d want 1 0", done_cnt, bad_prog);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008};
        salt = 32'h4444_0000;
        start(32'hFFFF_FFF8, 32'd8, 3);
        run(100, 100, 0, 0, -1, 100);
        n_run++;
        if (got_addr.size() != 3 || got_data.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_count: addr=%0d data=%0d want 3 3",
                     got_addr.size(), got_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_run++;
                if (got_addr[i] !== want[i] || got_data[i] !== word_of(want[i])) begin
                    n_fail++;
                    $display("FAIL wrap_word[%0d]: add=%h data=%h want %h %h", i,
                             got_addr[i], got_data[i], want[i], word_of(want[i]));
                end
            end
        end
    endtask

    task automatic test_zero();
        start(32'h0000_5000, 32'd4, 0);
        run(100, 100, 0, 0, -1, 50);
        n_run++;
        if (req_seen != 0 || got_data.size() != 0) begin
            n_fail++;
            $display("FAIL zero_req: req cycles=%0d words=%0d want 0 0",
                     req_seen, got_data.size());
        end
        n_run++;
        if (done_cnt != 1 || done_cyc != 0) begin
            n_fail++;
            $display("FAIL zero_done: pulses=%0d at cycle %0d want 1 at 0",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_ignore_start();
        salt = 32'h5555_0000;
        build_model(32'h4000, 32'd16, 5);
        start(32'h4000, 32'd16, 5);
        ctrl.base_addr  = 32'hDEAD_0000;
        ctrl.trans_size = 32'd2;
        run(100, 100, 0, 1, 2, 200);
        n_run++;
        if (got_addr.size() != 5 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL ign_count: addr=%0d done=%0d want 5 1",
                     got_addr.size(), done_cnt);
        end else begin
            foreach (exp_addr[i]) begin
                n_run++;
                if (got_addr[i] !== exp_addr[i]) begin
                    n_fail++;
                    $display("FAIL ign_addr[%0d]: got %h want %h", i,
                             got_addr[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_clear();
        salt = 32'h3333_0000;
        start(32'h2000, 32'd4, 8);
        tcdm_if.gnt = 1'b1;
        stream_if.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tcdm_if.gnt = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_run++;
        if ({tcdm_if.req, stream_if.valid, flags.ready_start, flags.done,
             flags.in_progress} !== 5'b00000) begin
            n_fail++;
            $display("FAIL clr_after: req/valid/rs/done/prog=%b want 00000",
                     {tcdm_if.req, stream_if.valid, flags.ready_start,
                      flags.done, flags.in_progress});
        end
        tcdm_if.r_valid = 1'b1;
        tcdm_if.r_data = 32'hBAD0_0001;
        @(negedge clk);
        n_run++;
        if ({stream_if.valid, flags.ready_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_late1: valid/rs=%b want 00",
                     {stream_if.valid, flags.ready_start});
        end
        tcdm_if.r_data = 32'hBAD0_0002;
        @(negedge clk);
        tcdm_if.r_valid = 1'b0;
        n_run++;
        if ({stream_if.valid, flags.ready_start, flags.in_progress} !== 3'b010) begin
            n_fail++;
            $display("FAIL clr_drained: valid/rs/prog=%b want 010",
                     {stream_if.valid, flags.ready_start, flags.in_progress});
        end
        stream_if.ready = 1'b0;
        build_model(32'h3000, 32'd4, 3);
        start(32'h3000, 32'd4, 3);
        run(100, 100, 0, 0, -1, 100);
        n_run++;
        if (got_data.size() != 3) begin
            n_fail++;
            $display("FAIL clr_next_count: got %0d words want 3", got_data.size());
        end else begin
            foreach (exp_data[i]) begin
                n_run++;
                if (got_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL clr_next[%0d]: got %h want %h", i,
                             got_data[i], exp_data[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_gnt();
        test_backpressure();
        test_wrap();
        test_zero();
        test_ignore_start();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
